// File: rtl/demux_pkg.sv
// Shared types and helpers for the demux_deser serial-to-word steering block.
package demux_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic MODE_AUTO = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    // True when an l-bit pointer can address every one of n positions.
    function automatic bit log2n_ok(input int n, input int l);
        if (n <= 1) return (l >= 1);
        return (l >= $clog2(n));
    endfunction

endpackage

// File: rtl/demux_wr_slice.sv
// One word bit position: a data flop and a "written" mask flop.
module demux_wr_slice (
    input  logic clk,
    input  logic rst_n,
    input  logic i_we,
    input  logic i_clr,
    input  logic i_d,
    output logic o_data,
    output logic o_mask
);

    logic r_data;
    logic r_mask;

    // Clear touches only the mask; the data bit keeps its value until rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 1'b0;
            r_mask <= 1'b0;
        end else begin
            if (i_we) begin
                r_data <= i_d;
                r_mask <= 1'b1;
            end else if (i_clr) begin
                r_mask <= 1'b0;
            end
        end
    end

    assign o_data = r_data;
    assign o_mask = r_mask;

endmodule

// File: rtl/demux_deser.sv
// Steers a 1-bit stream into N positions (auto counter or addressed) and hands the word off
// with valid/ready. Optional out_parity output when DEMUX_DESER_PARITY_EN is defined.
module demux_deser
    import demux_pkg::*;
#(
    parameter int N     = 8,
    parameter int log2N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             addr_mode,
    input  logic [log2N-1:0] sel,
    output logic [N-1:0]     data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     fill_mask,
    output logic             err_oor,
`ifdef DEMUX_DESER_PARITY_EN
    output logic             out_parity,
`endif
    output state_t           dbg_state
);

    localparam logic [log2N:0]   N_W      = (log2N+1)'(N);
    localparam logic [log2N-1:0] PTR_LAST = log2N'(N - 1);

    generate
        if (!log2n_ok(N, log2N)) begin : g_bad_log2n
            $error("demux_deser: log2N too small for N");
        end
    endgenerate

    state_t           r_state;
    logic [log2N-1:0] r_ptr;
    logic             r_mode;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_err_oor;

    logic             w_accept;
    logic             w_mode;
    logic [log2N-1:0] w_tgt;
    logic             w_in_range;
    logic             w_clr;
    logic             w_last;
    logic [N-1:0]     w_we;
    logic [N-1:0]     w_data;
    logic [N-1:0]     w_mask;

    // Handshake: a bit moves on a rising edge with in_valid && in_ready; a word moves with
    // out_valid && out_ready. in_ready and out_valid are mutually exclusive, one idle cycle between words.
    assign w_accept   = in_valid & r_in_ready;
    assign w_mode     = (w_mask == '0) ? addr_mode : r_mode;
    assign w_tgt      = (w_mode == MODE_ADDR) ? sel : r_ptr;
    assign w_in_range = ({1'b0, w_tgt} < N_W);
    assign w_clr      = r_out_valid & out_ready;
    assign w_last     = w_accept & (&(w_mask | w_we));

    generate
        for (genvar i = 0; i < N; i++) begin : g_slice
            localparam logic [log2N-1:0] IDX = log2N'(i);
            assign w_we[i] = w_accept & w_in_range & (w_tgt == IDX);
            demux_wr_slice u_slice (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_we   (w_we[i]),
                .i_clr  (w_clr),
                .i_d    (data_in),
                .o_data (w_data[i]),
                .o_mask (w_mask[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_ptr       <= '0;
            r_mode      <= MODE_AUTO;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err_oor   <= 1'b0;
        end else begin
            r_err_oor <= w_accept & ~w_in_range;
            if (w_accept && (w_mask == '0)) r_mode <= addr_mode;
            case (r_state)
                FILL: begin
                    if (w_accept && (w_mode == MODE_AUTO))
                        r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
                    if (w_last) begin
                        r_state     <= HOLD;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_clr) begin
                        r_state     <= FILL;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_ptr       <= '0;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

`ifdef DEMUX_DESER_PARITY_EN
    logic         r_parity;
    logic [N-1:0] w_data_next;

    // Parity must include the final bit landing on the same edge as FILL->HOLD.
    always_comb begin
        w_data_next = w_data;
        for (int i = 0; i < N; i++) begin
            if (w_we[i]) w_data_next[i] = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if ((r_state == FILL) && w_last) begin
            r_parity <= ^w_data_next;
        end else if (w_clr) begin
            r_parity <= 1'b0;
        end
    end

    assign out_parity = r_parity;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = w_data;
    assign fill_mask = w_mask;
    assign err_oor   = r_err_oor;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_demux_deser.sv
// Self-checking bench for demux_deser: N=8 instance for word traffic, N=6 instance for range errors.
module tb_demux_deser;
  import demux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance signals
  logic       rst_n, data_in, in_valid, addr_mode, out_ready;
  logic [2:0] sel;
  logic       in_ready, out_valid, err_oor;
  logic [7:0] data_out, fill_mask;
  state_t     dbg_state;

  // N=6 instance signals
  logic       d6_data_in, d6_in_valid, d6_addr_mode, d6_out_ready;
  logic [2:0] d6_sel;
  logic       d6_in_ready, d6_out_valid, d6_err_oor;
  logic [5:0] d6_data_out, d6_fill_mask;
  state_t     d6_dbg_state;

`ifdef DEMUX_DESER_PARITY_EN
  logic out_parity, d6_out_parity;
`endif

  demux_deser #(.N(8), .log2N(3)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .addr_mode(addr_mode), .sel(sel), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .fill_mask(fill_mask), .err_oor(err_oor),
`ifdef DEMUX_DESER_PARITY_EN
    .out_parity(out_parity),
`endif
    .dbg_state(dbg_state)
  );

  demux_deser #(.N(6), .log2N(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .data_in(d6_data_in), .in_valid(d6_in_valid), .in_ready(d6_in_ready),
    .addr_mode(d6_addr_mode), .sel(d6_sel), .data_out(d6_data_out), .out_valid(d6_out_valid),
    .out_ready(d6_out_ready), .fill_mask(d6_fill_mask), .err_oor(d6_err_oor),
`ifdef DEMUX_DESER_PARITY_EN
    .out_parity(d6_out_parity),
`endif
    .dbg_state(d6_dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       mode;
    logic [7:0] word;
    logic [23:0] ord;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bit at a negedge; returns at the negedge after the accepting edge.
  task automatic send_bit(input logic d, input logic m, input logic [2:0] s);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at %b expected 1", in_ready);
    end
    data_in = d; addr_mode = m; sel = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic mode, input logic [7:0] w, input logic [23:0] ord);
    logic [7:0] emask;
    logic [2:0] s;
    emask = '0;
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      s = mode ? ord[i*3 +: 3] : 3'(i);
      send_bit(w[s], mode, s);
      emask[s] = 1'b1;
      check("mask_step", fill_mask, emask);
      if (i < 7) check("early_valid", out_valid, 1'b0);
    end
    check("valid_latency", out_valid, 1'b1);
  endtask

  task automatic collect(input string name);
    int t;
    logic [7:0] exp;
    t = 0;
    while (out_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50 || exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_wait: out_valid %b queue size %0d", name, out_valid, exp_q.size());
      return;
    end
    exp = exp_q.pop_front();
    check({name, "_data"}, data_out, exp);
    check({name, "_mask_full"}, fill_mask, 8'hFF);
    check({name, "_ready_hold"}, in_ready, 1'b0);
    check({name, "_state_hold"}, dbg_state, HOLD);
`ifdef DEMUX_DESER_PARITY_EN
    check({name, "_parity"}, out_parity, ^exp);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, out_valid, 1'b0);
    check({name, "_ready_back"}, in_ready, 1'b1);
    check({name, "_mask_clr"}, fill_mask, 8'h00);
    check({name, "_data_kept"}, data_out, exp);
`ifdef DEMUX_DESER_PARITY_EN
    check({name, "_parity_clr"}, out_parity, 1'b0);
`endif
  endtask

  task automatic d6_bit(input logic d, input logic m, input logic [2:0] s);
    d6_data_in = d; d6_addr_mode = m; d6_sel = s; d6_in_valid = 1'b1;
    @(negedge clk);
    d6_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    vecs[0] = '{1'b0, 8'h4D, 24'h0};
    vecs[1] = '{1'b0, 8'h4C, 24'h0};
    vecs[2] = '{1'b0, 8'hFF, 24'h0};
    vecs[3] = '{1'b0, 8'h00, 24'h0};
    vecs[4] = '{1'b1, 8'hA5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}};
    vecs[5] = '{1'b1, 8'h3C, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    vecs[6] = '{1'b1, 8'h96, {3'd2, 3'd5, 3'd0, 3'd7, 3'd1, 3'd4, 3'd6, 3'd3}};
    vecs[7] = '{1'b1, 8'h5A, {3'd2, 3'd5, 3'd0, 3'd7, 3'd1, 3'd4, 3'd6, 3'd3}};

    // clock/reset
    rst_n = 1'b0;
    data_in = 1'b0; in_valid = 1'b0; addr_mode = 1'b0; sel = '0; out_ready = 1'b0;
    d6_data_in = 1'b0; d6_in_valid = 1'b0; d6_addr_mode = 1'b0; d6_sel = '0; d6_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", data_out, 8'h00);
    check("rst_mask", fill_mask, 8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_err", err_oor, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_state", dbg_state, FILL);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);

    // table-driven words
    for (int v = 0; v < 8; v++) begin
      send_word(vecs[v].mode, vecs[v].word, vecs[v].ord);
      collect("vec");
    end

    // random words, alternating placement modes
    for (int r = 0; r < 4; r++) begin
      w = 8'($urandom_range(0, 255));
      send_word(r[0], w, {3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd7, 3'd2, 3'd5});
      collect("rnd");
    end

    // addressed with overwrite; addr_mode drops mid-word and must be ignored
    send_bit(1'b1, 1'b1, 3'd3);
    send_bit(1'b1, 1'b0, 3'd7);
    send_bit(1'b1, 1'b0, 3'd6);
    send_bit(1'b1, 1'b0, 3'd5);
    send_bit(1'b1, 1'b0, 3'd4);
    send_bit(1'b1, 1'b0, 3'd2);
    send_bit(1'b1, 1'b0, 3'd1);
    check("ovw_mask7", fill_mask, 8'hFE);
    send_bit(1'b0, 1'b0, 3'd3);
    check("ovw_mask_same", fill_mask, 8'hFE);
    check("ovw_not_done", out_valid, 1'b0);
    check("ovw_data", data_out, 8'hF6);
    exp_q.push_back(8'hF7);
    send_bit(1'b1, 1'b0, 3'd0);
    collect("ovw");

    // auto word with addr_mode raised mid-word
    w = 8'hB2;
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) send_bit(w[i], (i == 0) ? 1'b0 : 1'b1, 3'd0);
    collect("auto_latch");

    // backpressure
    send_word(1'b0, 8'h69, 24'h0);
    for (int k = 0; k < 5; k++) begin
      data_in = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_ready", in_ready, 1'b0);
      check("bp_data", data_out, 8'h69);
      check("bp_mask", fill_mask, 8'hFF);
    end
    in_valid = 1'b0;
    collect("bp");
    send_word(1'b0, 8'h3C, 24'h0);
    collect("bp_next");

    // mid-word asynchronous reset
    send_bit(1'b1, 1'b0, 3'd0);
    send_bit(1'b1, 1'b0, 3'd0);
    send_bit(1'b1, 1'b0, 3'd0);
    check("mwr_mask_pre", fill_mask, 8'h07);
    #2 rst_n = 1'b0;
    #1;
    check("mwr_data", data_out, 8'h00);
    check("mwr_mask", fill_mask, 8'h00);
    check("mwr_valid", out_valid, 1'b0);
    check("mwr_ready", in_ready, 1'b1);
    check("mwr_state", dbg_state, FILL);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send_word(1'b0, 8'h4C, 24'h0);
    collect("mwr_next");

    // out-of-range on the N=6 instance
    d6_bit(1'b1, 1'b1, 3'd0);
    d6_bit(1'b1, 1'b1, 3'd1);
    check("oor_err_idle", d6_err_oor, 1'b0);
    check("oor_mask_pre", d6_fill_mask, 6'h03);
    d6_bit(1'b1, 1'b1, 3'd6);
    check("oor_err1", d6_err_oor, 1'b1);
    check("oor_mask1", d6_fill_mask, 6'h03);
    d6_bit(1'b1, 1'b1, 3'd7);
    check("oor_err2", d6_err_oor, 1'b1);
    check("oor_mask2", d6_fill_mask, 6'h03);
    check("oor_data", d6_data_out, 6'h03);
    @(negedge clk);
    check("oor_err_end", d6_err_oor, 1'b0);
    for (int s = 2; s < 6; s++) d6_bit(1'b0, 1'b1, 3'(s));
    check("oor_word_valid", d6_out_valid, 1'b1);
    check("oor_word_data", d6_data_out, 6'h03);
    check("oor_word_mask", d6_fill_mask, 6'h3F);
    d6_out_ready = 1'b1;
    @(negedge clk);
    d6_out_ready = 1'b0;
    check("oor_release", d6_out_valid, 1'b0);
    check("oor_mask_clr", d6_fill_mask, 6'h00);

    // N=6 auto words: pointer must stop at 5 and restart at 0
    w = 8'h2A;
    for (int i = 0; i < 6; i++) begin
      d6_bit(w[i], 1'b0, 3'd0);
      if (i < 5) check("n6_early_valid", d6_out_valid, 1'b0);
    end
    check("n6_valid", d6_out_valid, 1'b1);
    check("n6_data", d6_data_out, 6'h2A);
    check("n6_err", d6_err_oor, 1'b0);
    d6_out_ready = 1'b1;
    @(negedge clk);
    d6_out_ready = 1'b0;
    w = 8'h15;
    for (int i = 0; i < 6; i++) d6_bit(w[i], 1'b0, 3'd0);
    check("n6_valid2", d6_out_valid, 1'b1);
    check("n6_data2", d6_data_out, 6'h15);
    d6_out_ready = 1'b1;
    @(negedge clk);
    d6_out_ready = 1'b0;

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL queue_drain: %0d words left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
